// File: rtl/vector_proc_seq.sv
// -----------------------------------------------------------------------------
// vector_proc_seq
// Sequential vector processor: a word-addressed data memory, NREG vector
// registers of LANES x WORD_W bits, and a command FSM that executes
// LOAD / STORE / ADD / MUL one command at a time.
//
// Optional feature macro: VPROC_ADD_SAT_EN
//   defined     -> ADD saturates each lane to the signed WORD_W range
//   not defined -> ADD wraps modulo 2**WORD_W
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   mem_we     host memory write strobe, honoured only while idle
//   mem_addr   host memory address (read and write)
//   mem_wdata  host write data
//   mem_rdata  registered host read data, mem[mem_addr] one cycle later
//   cmd_valid  command present
//   cmd_ready  high while idle; command accepted on valid & ready
//   cmd_op     0=LOAD 1=STORE 2=ADD 3=MUL
//   cmd_rd     destination register
//   cmd_rs1    source 1 (also the STORE source)
//   cmd_rs2    source 2
//   cmd_addr   memory base address for LOAD/STORE
//   busy       high whenever a command is in progress
//   done       one-cycle pulse on command completion
//   rd_sel     debug register select
//   rd_vec     combinational view of register rd_sel
// -----------------------------------------------------------------------------
module vector_proc_seq #(
    parameter  int WORD_W    = 32,
    parameter  int LANES     = 16,
    parameter  int MEM_DEPTH = 512,
    parameter  int ADDR_W    = 9,
    parameter  int NREG      = 4,
    localparam int REG_W     = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_we,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [WORD_W-1:0]       mem_wdata,
    output logic [WORD_W-1:0]       mem_rdata,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [REG_W-1:0]        cmd_rd,
    input  logic [REG_W-1:0]        cmd_rs1,
    input  logic [REG_W-1:0]        cmd_rs2,
    input  logic [ADDR_W-1:0]       cmd_addr,
    output logic                    busy,
    output logic                    done,
    input  logic [REG_W-1:0]        rd_sel,
    output logic [LANES*WORD_W-1:0] rd_vec
);

    localparam int VEC_W  = LANES * WORD_W;
    localparam int LANE_W = $clog2(LANES + 1);

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd1;
    localparam logic [1:0] OP_ADD   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_ADD,
        S_MUL,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [LANE_W-1:0]   r_lane;
    logic [REG_W-1:0]    r_rd;
    logic [REG_W-1:0]    r_rd_hi;
    logic [ADDR_W-1:0]   r_base;
    logic [VEC_W-1:0]    r_src1;
    logic [VEC_W-1:0]    r_src2;
    logic [VEC_W-1:0]    r_vreg [NREG];
    logic                r_busy;
    logic                r_done;
    logic                r_ready;

    logic [WORD_W-1:0]   r_mem [MEM_DEPTH];
    logic [WORD_W-1:0]   r_mem_rdata;
    logic [WORD_W-1:0]   r_ld_data;

    logic [ADDR_W:0]       w_addr_sum;
    logic [ADDR_W-1:0]     w_lane_addr;
    logic [WORD_W-1:0]     w_src1_lane;
    logic [WORD_W-1:0]     w_src2_lane;
    logic signed [2*WORD_W-1:0] w_prod;
    logic [VEC_W-1:0]      w_add_vec;

    // Memory address for the current lane, wrapped into [0, MEM_DEPTH).
    // base < MEM_DEPTH and lane <= LANES, so one conditional subtract suffices.
    assign w_addr_sum  = {1'b0, r_base} + (ADDR_W+1)'(r_lane);
    assign w_lane_addr = (w_addr_sum >= (ADDR_W+1)'(MEM_DEPTH))
                       ? ADDR_W'(w_addr_sum - (ADDR_W+1)'(MEM_DEPTH))
                       : w_addr_sum[ADDR_W-1:0];

    // Operands come from copies latched at accept, so destination aliasing
    // with a source never corrupts later lanes.
    assign w_src1_lane = r_src1[r_lane*WORD_W +: WORD_W];
    assign w_src2_lane = r_src2[r_lane*WORD_W +: WORD_W];
    assign w_prod      = $signed(w_src1_lane) * $signed(w_src2_lane);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_add
            logic [WORD_W-1:0] w_a;
            logic [WORD_W-1:0] w_b;
            logic [WORD_W-1:0] w_sum;
            assign w_a   = r_src1[gi*WORD_W +: WORD_W];
            assign w_b   = r_src2[gi*WORD_W +: WORD_W];
            assign w_sum = w_a + w_b;
`ifdef VPROC_ADD_SAT_EN
            // Signed overflow: operands agree in sign but the sum does not.
            logic w_ovf;
            assign w_ovf = (w_a[WORD_W-1] == w_b[WORD_W-1]) &&
                           (w_sum[WORD_W-1] != w_a[WORD_W-1]);
            assign w_add_vec[gi*WORD_W +: WORD_W] =
                !w_ovf         ? w_sum :
                w_a[WORD_W-1]  ? {1'b1, {(WORD_W-1){1'b0}}} :
                                 {1'b0, {(WORD_W-1){1'b1}}};
`else
            assign w_add_vec[gi*WORD_W +: WORD_W] = w_sum;
`endif
        end
    endgenerate

    // Command FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lane  <= '0;
            r_rd    <= '0;
            r_rd_hi <= '0;
            r_base  <= '0;
            r_src1  <= '0;
            r_src2  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
            for (int r = 0; r < NREG; r++) begin
                r_vreg[r] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_rd    <= cmd_rd;
                        r_rd_hi <= (cmd_rd == REG_W'(NREG-1)) ? '0 : cmd_rd + 1'b1;
                        r_base  <= cmd_addr;
                        r_src1  <= r_vreg[cmd_rs1];
                        r_src2  <= r_vreg[cmd_rs2];
                        r_lane  <= '0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        case (cmd_op)
                            OP_LOAD:  r_state <= S_LOAD;
                            OP_STORE: r_state <= S_STORE;
                            OP_ADD:   r_state <= S_ADD;
                            default:  r_state <= S_MUL;
                        endcase
                    end
                end
                S_LOAD: begin
                    // Read for lane k is issued while r_lane==k; its data
                    // arrives and is written one cycle later.
                    if (r_lane != '0) begin
                        r_vreg[r_rd][(r_lane-1'b1)*WORD_W +: WORD_W] <= r_ld_data;
                    end
                    if (r_lane == LANE_W'(LANES)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_lane <= r_lane + 1'b1;
                    end
                end
                S_STORE: begin
                    if (r_lane == LANE_W'(LANES-1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_lane <= r_lane + 1'b1;
                    end
                end
                S_ADD: begin
                    r_vreg[r_rd] <= w_add_vec;
                    r_state      <= S_DONE;
                    r_done       <= 1'b1;
                end
                S_MUL: begin
                    r_vreg[r_rd][r_lane*WORD_W +: WORD_W]    <= w_prod[WORD_W-1:0];
                    r_vreg[r_rd_hi][r_lane*WORD_W +: WORD_W] <= w_prod[2*WORD_W-1:WORD_W];
                    if (r_lane == LANE_W'(LANES-1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_lane <= r_lane + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Memory write port. A reset cycle writes nothing, so an aborted STORE
    // keeps exactly the lanes completed before reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_STORE) begin
                r_mem[w_lane_addr] <= w_src1_lane;
            end else if ((r_state == S_IDLE) && mem_we) begin
                r_mem[mem_addr] <= mem_wdata;
            end
        end
    end

    // Registered read ports; a read colliding with a write returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_rdata <= '0;
        end else begin
            r_mem_rdata <= r_mem[mem_addr];
        end
        r_ld_data <= r_mem[w_lane_addr];
    end

    assign mem_rdata = r_mem_rdata;
    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_vec    = r_vreg[rd_sel];

endmodule

// File: tb/tb_vector_proc_seq.sv
module tb_vector_proc_seq;

    localparam int WORD_W    = 32;
    localparam int LANES     = 16;
    localparam int MEM_DEPTH = 512;
    localparam int ADDR_W    = 9;
    localparam int NREG      = 4;
    localparam int REG_W     = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [WORD_W-1:0]       mem_wdata;
    logic [WORD_W-1:0]       mem_rdata;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd_op;
    logic [REG_W-1:0]        cmd_rd;
    logic [REG_W-1:0]        cmd_rs1;
    logic [REG_W-1:0]        cmd_rs2;
    logic [ADDR_W-1:0]       cmd_addr;
    logic                    busy;
    logic                    done;
    logic [REG_W-1:0]        rd_sel;
    logic [LANES*WORD_W-1:0] rd_vec;

    vector_proc_seq #(
        .WORD_W(WORD_W), .LANES(LANES), .MEM_DEPTH(MEM_DEPTH),
        .ADDR_W(ADDR_W), .NREG(NREG)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_addr(cmd_addr),
        .busy(busy), .done(done), .rd_sel(rd_sel), .rd_vec(rd_vec)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: memory words and register lanes.
    logic [31:0] m_mem [MEM_DEPTH];
    logic [31:0] m_reg [NREG][LANES];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input int a, input logic [31:0] d);
        @(negedge clk);
        mem_we    = 1'b1;
        mem_addr  = a[ADDR_W-1:0];
        mem_wdata = d;
        m_mem[a]  = d;
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    task automatic get_lane(input int r, input int l, output logic [31:0] v);
        @(negedge clk);
        rd_sel = r[REG_W-1:0];
        #1;
        v = rd_vec[l*32 +: 32];
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < NREG; r++) begin
            @(negedge clk);
            rd_sel = r[REG_W-1:0];
            #1;
            for (int l = 0; l < LANES; l++) begin
                chk($sformatf("%s r%0d l%0d", tag, r, l), rd_vec[l*32 +: 32], m_reg[r][l]);
            end
        end
    endtask

    task automatic check_mem(input string tag, input int a);
        @(negedge clk);
        mem_addr = a[ADDR_W-1:0];
        @(negedge clk);
        chk($sformatf("%s mem[%0d]", tag, a), mem_rdata, m_mem[a]);
    endtask

    // Issue one command, wait for done (bounded), check latency and the
    // done pulse, then advance the reference model.
    task automatic do_cmd(input string tag, input int op, input int rd, input int rs1,
                          input int rs2, input int addr);
        int cyc;
        int exp_lat;
        logic [31:0] s1 [LANES];
        logic [31:0] s2 [LANES];
        longint p;
        @(negedge clk);
        cyc = 0;
        while (!cmd_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op[1:0];
        cmd_rd    = rd[REG_W-1:0];
        cmd_rs1   = rs1[REG_W-1:0];
        cmd_rs2   = rs2[REG_W-1:0];
        cmd_addr  = addr[ADDR_W-1:0];
        @(negedge clk);
        cyc = 1;
        chk({tag, " busy"}, busy, 1);
        // While busy: noise on command inputs and host writes aimed at the
        // command's own address window; all must be ignored.
        while (!done && cyc < 100) begin
            cmd_valid = 1'($urandom);
            cmd_op    = 2'($urandom);
            cmd_rd    = REG_W'($urandom);
            cmd_addr  = ADDR_W'($urandom);
            mem_we    = 1'($urandom);
            mem_addr  = ADDR_W'((addr + $urandom_range(0, LANES-1)) % MEM_DEPTH);
            mem_wdata = $urandom;
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        mem_we    = 1'b0;
        exp_lat = (op == 0) ? LANES + 2 : (op == 2) ? 2 : LANES + 1;
        chk({tag, " latency"}, cyc, exp_lat);

        for (int i = 0; i < LANES; i++) begin
            s1[i] = m_reg[rs1][i];
            s2[i] = m_reg[rs2][i];
        end
        for (int i = 0; i < LANES; i++) begin
            case (op)
                0: m_reg[rd][i] = m_mem[(addr + i) % MEM_DEPTH];
                1: m_mem[(addr + i) % MEM_DEPTH] = s1[i];
                2: begin
`ifdef VPROC_ADD_SAT_EN
                    p = longint'($signed(s1[i])) + longint'($signed(s2[i]));
                    if (p > 64'sd2147483647)       p = 64'sd2147483647;
                    else if (p < -64'sd2147483648) p = -64'sd2147483648;
                    m_reg[rd][i] = p[31:0];
`else
                    m_reg[rd][i] = s1[i] + s2[i];
`endif
                end
                default: begin
                    p = longint'($signed(s1[i])) * longint'($signed(s2[i]));
                    m_reg[rd][i]               = p[31:0];
                    m_reg[(rd + 1) % NREG][i]  = p[63:32];
                end
            endcase
        end
        @(negedge clk);
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " ready_back"}, cmd_ready, 1);
    endtask

    logic [31:0] v;
    int          op, a;

    initial begin
        rst = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_addr = '0; rd_sel = '0;
        for (int r = 0; r < NREG; r++)
            for (int l = 0; l < LANES; l++) m_reg[r][l] = '0;

        // 1. reset
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst ready", cmd_ready, 1);
        chk("rst rdata", mem_rdata, 0);
        rst = 1'b0;
        check_regs("rst");

        // Fill memory: words 0..15 = i+1, rest random.
        for (int i = 0; i < MEM_DEPTH; i++)
            host_write(i, (i < LANES) ? 32'(i + 1) : $urandom);

        // 2. LOAD from 0
        do_cmd("load0", 0, 0, 0, 0, 0);
        check_regs("load0");
        get_lane(0, 15, v);
        chk("load0 lane15", v, 32'd16);

        // 3. LOAD across the top of memory
        do_cmd("loadwrap", 0, 1, 0, 0, 510);
        check_regs("loadwrap");
        get_lane(1, 2, v);
        chk("loadwrap lane2", v, 32'd1);

        // 4. signed MUL, then high half wrapping into register 0
        for (int i = 0; i < LANES; i++) host_write(i, 32'h0000_0002);
        for (int i = 0; i < LANES; i++) host_write(16 + i, 32'hFFFF_FFFF);
        do_cmd("ldA0", 0, 0, 0, 0, 0);
        do_cmd("ldA1", 0, 1, 0, 0, 16);
        do_cmd("mul2", 3, 2, 0, 1, 0);
        check_regs("mul2");
        get_lane(2, 7, v);
        chk("mul2 lo", v, 32'hFFFF_FFFE);
        get_lane(3, 7, v);
        chk("mul2 hi", v, 32'hFFFF_FFFF);
        do_cmd("mul3", 3, 3, 0, 1, 0);
        check_regs("mul3");
        get_lane(0, 4, v);
        chk("mul3 hi->A0", v, 32'hFFFF_FFFF);

        // 5. ADD overflow boundary, plus aliasing rd==rs1
        for (int i = 0; i < LANES; i++) host_write(32 + i, 32'h7FFF_FFFF);
        for (int i = 0; i < LANES; i++) host_write(48 + i, 32'h0000_0001);
        do_cmd("ldA0b", 0, 0, 0, 0, 32);
        do_cmd("ldA1b", 0, 1, 0, 0, 48);
        do_cmd("add", 2, 2, 0, 1, 0);
        get_lane(2, 0, v);
`ifdef VPROC_ADD_SAT_EN
        chk("add ovf", v, 32'h7FFF_FFFF);
`else
        chk("add ovf", v, 32'h8000_0000);
`endif
        do_cmd("addalias", 2, 0, 0, 1, 0);
        check_regs("add");

        // MUL with destination aliasing both sources
        for (int i = 0; i < LANES; i++) host_write(64 + i, $urandom);
        do_cmd("ldA0c", 0, 0, 0, 0, 64);
        do_cmd("mulalias", 3, 0, 0, 0, 0);
        check_regs("mulalias");

        // 6a. STORE with host writes attempted mid-command
        do_cmd("store", 1, 0, 2, 0, 100);
        for (int i = 0; i < LANES; i++) check_mem("store", 100 + i);
        check_regs("store");

        // 6b. STORE aborted by reset at lane 5
        for (int i = 0; i < LANES; i++) host_write(300 + i, $urandom);
        do_cmd("ldA2", 0, 2, 0, 0, 300);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_rs1 = 2'd2; cmd_addr = 9'd100;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("abort no_done", done, 0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) m_mem[100 + i] = m_reg[2][i];
        for (int r = 0; r < NREG; r++)
            for (int l = 0; l < LANES; l++) m_reg[r][l] = '0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort ready", cmd_ready, 1);
        @(negedge clk);
        chk("abort done2", done, 0);
        for (int i = 0; i < LANES; i++) check_mem("abort", 100 + i);
        check_regs("abort");

        // Randomized commands against the model
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 2) == 0)
                host_write($urandom_range(0, MEM_DEPTH-1), $urandom);
            op = $urandom_range(0, 3);
            a  = $urandom_range(0, MEM_DEPTH-1);
            do_cmd($sformatf("rnd%0d", t), op, $urandom_range(0, NREG-1),
                   $urandom_range(0, NREG-1), $urandom_range(0, NREG-1), a);
            check_regs($sformatf("rnd%0d", t));
            if (op == 1)
                for (int i = 0; i < LANES; i++)
                    check_mem($sformatf("rnd%0d", t), (a + i) % MEM_DEPTH);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
